image_buffer: RTL and testbench
===============================

// Module: image_buffer
// PURPOSE
//  Frame store on the image-stream bus (`I_*` fields of image_defs.v). Captures one full frame from
//  image_in into an internal RAM of `IS_PIXEL_COUNT(IS)` pixels, then replays it on image_out on demand.
//  An optional random-access read port exposes any stored pixel by (x,y). Sits between a source
//  (camera/generator) and a sink (display/processing) as a frame decoupler.
// PARAMETERS
//  IS                   `IS_DEFAULT  packed image spec: width, height, data width, C0/C1/C2/alpha/Z widths
//  ImplementAccessPort  0            1 = build (x,y) read port; 0 = buffer_out_data tied to 0
// PORTS
//  clock                 in     1                 single clock, rising edge
//  reset                 in     1                 asynchronous, active-high
//  in_request_external   in     1                 level: arm capture of frames from image_in
//  out_request_external  in     1                 level: start replay without a sink Request
//  image_in              inout  `I_w(IS)          in: Start,Stop,Data,Error,Valid; driven: Request,Cancel,Ready
//  image_out             inout  `I_w(IS)          driven: Start,Stop,Data,Error,Valid; in: Request,Cancel,Ready
//  in_receiving          out    1                 capture FSM not idle (requesting or receiving)
//  out_sending           out    1                 replay in progress
//  buffer_out_x          in     `IS_WIDTH_WIDTH   access-port column
//  buffer_out_y          in     `IS_HEIGHT_WIDTH  access-port row
//  buffer_out_data       out    `IS_DATA_WIDTH    pixel at (x,y), combinational (async) read
// BEHAVIOUR
//  Reset: all driven bus fields 0 (in Request/Ready/Cancel; out Start/Stop/Data/Valid/Error);
//   in_receiving=out_sending=0; both FSMs IDLE; RAM contents not cleared.
//  Addressing: addr = y*Width + x, width clog2(PixelCount); pixel i of a stream -> addr i.
//  Capture FSM IDLE -> REQ -> RECV -> IDLE:
//   IDLE: if in_request_external=1 and replay not active -> REQ next edge.
//   REQ/RECV: image_in Request=1 and Ready=1 (visible 1 clock after in_request_external rises);
//    in_receiving=1. Each clock with Valid&Ready writes Data to RAM[wa], wa++.
//    Valid&Start: write at addr 0, wa=1 (restart mid-frame allowed), state RECV.
//    Valid before any Start in REQ: ignored. wa>=PixelCount: writes dropped (no wrap).
//    Valid&Stop in RECV: write, Request/Ready drop next edge, -> IDLE, frame_valid=1.
//    Error=1: abort, -> IDLE, frame_valid unchanged. Re-arms if in_request_external still high.
//   image_in Cancel always 0.
//  Replay FSM IDLE -> SEND -> IDLE:
//   Starts when (image_out Request | out_request_external) and capture not RECV; out_sending=1.
//   Emits PixelCount pixels addr 0..PixelCount-1 in order (regardless of frame_valid); registered
//    RAM read, first Valid within 3 clocks of request; Start=1 on pixel 0 only, Stop=1 on last only.
//   A pixel is consumed on a clock with Valid&Ready; Ready=0 stalls with Data/Start/Stop/Valid held.
//   Sustained throughput 1 pixel/clock while Ready=1; full 10x10 frame done within 110 clocks.
//   After last pixel consumed: Valid=0, out_sending=0, -> IDLE; restarts only on a new request.
//   image_out Cancel=1 while SEND: abort, Valid=0, -> IDLE. image_out Error always 0.
//  Access port: buffer_out_data = RAM[y*Width+x] combinationally (no clock); out-of-range x/y -> 0.
//  Simultaneous: capture start request loses to an active replay; replay request waits for RECV end.
//  Reset mid-operation: both FSMs to IDLE immediately; partially written RAM kept.
// TESTING  (IS: 10x10, RGB 8/8/8, PixelCount=100)
//  Reset -> in_receiving=0, out_sending=0, image_in Ready=0, Request=0, Cancel=0.
//  in_request_external=1, one clock -> image_in Request=1, Ready=1; stay Ready over 100 pixels.
//  Write data=i%2, Start at i=0, Stop at i=99; then out Request=Ready=1 -> 100 Valid pixels,
//   data=i%2, Start only i=0, Stop only i=99, all within 110 clocks.
//  After capture, set (x,y)=(3,0) -> buffer_out_data=1 after #1; (0,1) -> 0; full 10x10 dump matches.
//  During replay toggle out Ready 0 for 5 clocks -> no pixel lost/duplicated, Valid/Data held.
//  Assert in Error at pixel 50 -> capture aborts, Request re-asserts; reset mid-replay -> outputs 0.

Source files
------------

// File: rtl/image_buffer.sv
// Single-frame store on the image-stream bus: captures one frame into RAM, replays it on demand,
// and optionally exposes any stored pixel through a combinational (x,y) read port.
module image_buffer #(
    parameter int WIDTH               = 10,
    parameter int HEIGHT              = 10,
    parameter int DATA_W              = 24,
    parameter int ImplementAccessPort = 0
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic                      in_request_external,
    input  logic                      out_request_external,
    input  logic                      image_in_start,
    input  logic                      image_in_stop,
    input  logic [DATA_W-1:0]         image_in_data,
    input  logic                      image_in_error,
    input  logic                      image_in_valid,
    output logic                      image_in_request,
    output logic                      image_in_cancel,
    output logic                      image_in_ready,
    output logic                      image_out_start,
    output logic                      image_out_stop,
    output logic [DATA_W-1:0]         image_out_data,
    output logic                      image_out_error,
    output logic                      image_out_valid,
    input  logic                      image_out_request,
    input  logic                      image_out_cancel,
    input  logic                      image_out_ready,
    output logic                      in_receiving,
    output logic                      out_sending,
    output logic                      frame_valid,
    input  logic [$clog2(WIDTH)-1:0]  buffer_out_x,
    input  logic [$clog2(HEIGHT)-1:0] buffer_out_y,
    output logic [DATA_W-1:0]         buffer_out_data
);
    localparam int PC = WIDTH * HEIGHT;
    localparam int AW = $clog2(PC);
    localparam int CW = $clog2(PC + 1);

    typedef enum logic [1:0] {C_IDLE, C_REQ, C_RECV} cap_state_t;
    typedef enum logic {R_IDLE, R_SEND} rep_state_t;

    logic [DATA_W-1:0] r_ram [PC];

    cap_state_t        r_cstate, w_cnext;
    logic [CW-1:0]     r_wa, w_wa_next;
    logic              r_frame_valid, w_fv_next;
    logic              w_we;
    logic [AW-1:0]     w_waddr;

    rep_state_t        r_rstate, w_rnext;
    logic [CW-1:0]     r_ra, w_ra_next;
    logic              r_out_valid, w_ov_next;
    logic              r_out_start, w_os_next;
    logic              r_out_stop, w_oe_next;
    logic [DATA_W-1:0] r_out_data;
    logic              w_rd_en;

    logic              w_acc_ok;
    logic [AW-1:0]     w_acc_addr;
    logic [DATA_W-1:0] w_acc_data;

    // Capture FSM: a Start always rewinds to address 0, so a source may restart mid-frame
    always_comb begin
        w_cnext   = r_cstate;
        w_wa_next = r_wa;
        w_fv_next = r_frame_valid;
        w_we      = 1'b0;
        w_waddr   = r_wa[AW-1:0];
        case (r_cstate)
            C_IDLE: begin
                if (in_request_external && r_rstate == R_IDLE)
                    w_cnext = C_REQ;
            end
            C_REQ, C_RECV: begin
                if (image_in_error) begin
                    w_cnext = C_IDLE;
                end else if (image_in_valid && image_in_start) begin
                    w_we      = 1'b1;
                    w_waddr   = '0;
                    w_wa_next = CW'(1);
                    w_cnext   = image_in_stop ? C_IDLE : C_RECV;
                    if (image_in_stop)
                        w_fv_next = 1'b1;
                end else if (image_in_valid && r_cstate == C_RECV) begin
                    if (r_wa < CW'(PC)) begin
                        w_we      = 1'b1;
                        w_wa_next = r_wa + CW'(1);
                    end
                    if (image_in_stop) begin
                        w_cnext   = C_IDLE;
                        w_fv_next = 1'b1;
                    end
                end
            end
            default: w_cnext = C_IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_cstate      <= C_IDLE;
            r_wa          <= '0;
            r_frame_valid <= 1'b0;
        end else begin
            r_cstate      <= w_cnext;
            r_wa          <= w_wa_next;
            r_frame_valid <= w_fv_next;
        end
    end

    // RAM contents survive reset
    always_ff @(posedge clock) begin
        if (w_we)
            r_ram[w_waddr] <= image_in_data;
    end

    // Replay FSM: the output register only reloads when empty or consumed, which gives stall hold
    always_comb begin
        w_rnext   = r_rstate;
        w_ra_next = r_ra;
        w_ov_next = r_out_valid;
        w_os_next = r_out_start;
        w_oe_next = r_out_stop;
        w_rd_en   = 1'b0;
        case (r_rstate)
            R_IDLE: begin
                if ((image_out_request || out_request_external) && r_cstate != C_RECV) begin
                    w_rnext   = R_SEND;
                    w_ra_next = '0;
                    w_ov_next = 1'b0;
                end
            end
            R_SEND: begin
                if (image_out_cancel) begin
                    w_rnext   = R_IDLE;
                    w_ov_next = 1'b0;
                    w_os_next = 1'b0;
                    w_oe_next = 1'b0;
                end else if (!r_out_valid || image_out_ready) begin
                    if (r_ra < CW'(PC)) begin
                        w_rd_en   = 1'b1;
                        w_ov_next = 1'b1;
                        w_os_next = (r_ra == '0);
                        w_oe_next = (r_ra == CW'(PC - 1));
                        w_ra_next = r_ra + CW'(1);
                    end else begin
                        w_rnext   = R_IDLE;
                        w_ov_next = 1'b0;
                        w_os_next = 1'b0;
                        w_oe_next = 1'b0;
                    end
                end
            end
            default: w_rnext = R_IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_rstate    <= R_IDLE;
            r_ra        <= '0;
            r_out_valid <= 1'b0;
            r_out_start <= 1'b0;
            r_out_stop  <= 1'b0;
            r_out_data  <= '0;
        end else begin
            r_rstate    <= w_rnext;
            r_ra        <= w_ra_next;
            r_out_valid <= w_ov_next;
            r_out_start <= w_os_next;
            r_out_stop  <= w_oe_next;
            if (w_rd_en)
                r_out_data <= r_ram[r_ra[AW-1:0]];
        end
    end

    always_comb begin
        w_acc_ok   = (int'(buffer_out_x) < WIDTH) && (int'(buffer_out_y) < HEIGHT);
        w_acc_addr = AW'(int'(buffer_out_y) * WIDTH + int'(buffer_out_x));
        w_acc_data = '0;
        if (ImplementAccessPort != 0 && w_acc_ok)
            w_acc_data = r_ram[w_acc_addr];
    end

    assign buffer_out_data  = w_acc_data;
    assign image_in_request = (r_cstate != C_IDLE);
    assign image_in_ready   = (r_cstate != C_IDLE);
    assign image_in_cancel  = 1'b0;
    assign in_receiving     = (r_cstate != C_IDLE);
    assign frame_valid      = r_frame_valid;
    assign image_out_valid  = r_out_valid;
    assign image_out_start  = r_out_start;
    assign image_out_stop   = r_out_stop;
    assign image_out_data   = r_out_data;
    assign image_out_error  = 1'b0;
    assign out_sending      = (r_rstate == R_SEND);

endmodule

// File: tb/tb_image_buffer.sv
// Scoreboard bench for image_buffer: directed capture/replay/access-port vectors on a 10x10 frame.
module tb_image_buffer;
    localparam int W  = 10;
    localparam int H  = 10;
    localparam int DW = 24;
    localparam int PC = W * H;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_req_ext, out_req_ext;
    logic          in_start, in_stop, in_error, in_valid;
    logic [DW-1:0] in_data;
    logic          image_in_request, image_in_cancel, image_in_ready;
    logic          image_out_start, image_out_stop, image_out_error, image_out_valid;
    logic [DW-1:0] image_out_data;
    logic          out_request, out_cancel, out_ready;
    logic          in_receiving, out_sending, frame_valid;
    logic [3:0]    acc_x, acc_y;
    logic [DW-1:0] acc_data;

    typedef struct packed {
        logic [DW-1:0] d;
        logic          s;
        logic          e;
    } pix_t;

    pix_t exp_q[$];
    pix_t mon_p;
    int   n_pass  = 0;
    int   n_total = 0;
    int   n_popped = 0;
    bit   mon_en = 1'b1;

    always #5 clk = ~clk;

    image_buffer #(.WIDTH(W), .HEIGHT(H), .DATA_W(DW), .ImplementAccessPort(1)) dut (
        .clock(clk), .reset(rst),
        .in_request_external(in_req_ext), .out_request_external(out_req_ext),
        .image_in_start(in_start), .image_in_stop(in_stop), .image_in_data(in_data),
        .image_in_error(in_error), .image_in_valid(in_valid),
        .image_in_request(image_in_request), .image_in_cancel(image_in_cancel),
        .image_in_ready(image_in_ready),
        .image_out_start(image_out_start), .image_out_stop(image_out_stop),
        .image_out_data(image_out_data), .image_out_error(image_out_error),
        .image_out_valid(image_out_valid),
        .image_out_request(out_request), .image_out_cancel(out_cancel),
        .image_out_ready(out_ready),
        .in_receiving(in_receiving), .out_sending(out_sending), .frame_valid(frame_valid),
        .buffer_out_x(acc_x), .buffer_out_y(acc_y), .buffer_out_data(acc_data)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    function automatic logic [DW-1:0] pix_val(input int mode, input int i);
        case (mode)
            0:       return DW'(i % 2);
            1:       return DW'(32'h0A0000 + i * 3);
            default: return DW'(32'h500000 + i);
        endcase
    endfunction

    // Monitor: every consumed output pixel is matched against the queue head
    always @(negedge clk) begin
        if (mon_en && !rst && image_out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                chk("extra_pixel", 32'(image_out_data), 32'hFFFFFFFF);
            end else begin
                mon_p = exp_q.pop_front();
                chk("replay_pixel", 32'({image_out_data, image_out_start, image_out_stop}), 32'(mon_p));
                n_popped++;
            end
        end
    end

    task automatic arm(input bit keep);
        @(posedge clk); #1;
        in_req_ext = 1'b1;
        @(negedge clk);
        chk("arm_req_not_yet", 32'(image_in_request), 32'd0);
        @(posedge clk); #1;
        if (!keep) in_req_ext = 1'b0;
        @(negedge clk);
        chk("arm_request", 32'(image_in_request), 32'd1);
        chk("arm_ready", 32'(image_in_ready), 32'd1);
        chk("arm_receiving", 32'(in_receiving), 32'd1);
    endtask

    task automatic capture(input int mode, input int err_at);
        int miss = 0;
        int last = (err_at >= 0) ? err_at : PC - 1;
        for (int i = 0; i <= last; i++) begin
            @(posedge clk); #1;
            in_valid = 1'b1;
            in_data  = pix_val(mode, i);
            in_start = (i == 0);
            in_stop  = (i == PC - 1);
            in_error = (i == err_at);
            @(negedge clk);
            if (!image_in_ready) miss++;
        end
        @(posedge clk); #1;
        in_valid = 1'b0; in_start = 1'b0; in_stop = 1'b0; in_error = 1'b0;
        chk("in_ready_held", 32'(miss), 32'd0);
    endtask

    task automatic replay(input int mode, input bit use_ext, input int stall_at, input int budget);
        int cyc = 0;
        bit stalled = 1'b0;
        n_popped = 0;
        for (int i = 0; i < PC; i++)
            exp_q.push_back({pix_val(mode, i), i == 0, i == PC - 1});
        @(posedge clk); #1;
        out_ready = 1'b1;
        if (use_ext) out_req_ext = 1'b1; else out_request = 1'b1;
        @(posedge clk); #1;
        out_req_ext = 1'b0; out_request = 1'b0;
        cyc = 1;
        while (exp_q.size() != 0 && cyc < 300) begin
            if (!stalled && stall_at >= 0 && n_popped >= stall_at) begin
                out_ready = 1'b0;
                stalled   = 1'b1;
                repeat (5) begin
                    @(negedge clk);
                    chk("stall_valid_held", 32'(image_out_valid), 32'd1);
                    chk("stall_data_held", 32'(image_out_data), 32'(exp_q[0].d));
                    @(posedge clk); #1;
                    cyc++;
                end
                out_ready = 1'b1;
            end
            @(posedge clk); #1;
            cyc++;
        end
        chk("replay_in_budget", 32'(cyc <= budget), 32'd1);
        @(negedge clk);
        chk("replay_end_sending", 32'(out_sending), 32'd0);
        chk("replay_end_valid", 32'(image_out_valid), 32'd0);
    endtask

    task automatic probe(input string name, input int x, input int y, input logic [DW-1:0] exp);
        acc_x = 4'(x);
        acc_y = 4'(y);
        #1;
        chk(name, 32'(acc_data), 32'(exp));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        in_req_ext = 0; out_req_ext = 0;
        in_start = 0; in_stop = 0; in_error = 0; in_valid = 0; in_data = '0;
        out_request = 0; out_cancel = 0; out_ready = 0;
        acc_x = 0; acc_y = 0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_in_receiving", 32'(in_receiving), 32'd0);
        chk("rst_out_sending", 32'(out_sending), 32'd0);
        chk("rst_in_ready", 32'(image_in_ready), 32'd0);
        chk("rst_in_request", 32'(image_in_request), 32'd0);
        chk("rst_in_cancel", 32'(image_in_cancel), 32'd0);
        chk("rst_out_valid", 32'(image_out_valid), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;

        // Frame A: alternating 0/1, full-rate replay
        arm(1'b0);
        capture(0, -1);
        @(negedge clk);
        chk("capA_request_drop", 32'(image_in_request), 32'd0);
        chk("capA_receiving_drop", 32'(in_receiving), 32'd0);
        chk("capA_frame_valid", 32'(frame_valid), 32'd1);
        replay(0, 1'b0, -1, 110);

        probe("acc_3_0", 3, 0, 24'd1);
        probe("acc_0_1", 0, 1, 24'd0);
        for (int y = 0; y < H; y++)
            for (int x = 0; x < W; x++)
                probe("acc_dump", x, y, pix_val(0, y * W + x));
        probe("acc_x_range", 11, 0, 24'd0);
        probe("acc_y_range", 5, 12, 24'd0);

        // Frame B: distinct values, replay via external request with a 5-clock stall
        arm(1'b0);
        capture(1, -1);
        replay(1, 1'b1, 20, 120);
        probe("accB_7_3", 7, 3, pix_val(1, 37));

        // Frame C aborted by Error at pixel 50
        arm(1'b1);
        capture(2, 50);
        @(negedge clk);
        chk("err_abort_request", 32'(image_in_request), 32'd0);
        @(negedge clk);
        chk("err_rearm_request", 32'(image_in_request), 32'd1);
        chk("err_frame_valid_kept", 32'(frame_valid), 32'd1);
        @(posedge clk); #1;
        in_req_ext = 1'b0;
        probe("err_addr49_new", 9, 4, pix_val(2, 49));
        probe("err_addr50_old", 0, 5, pix_val(1, 50));

        // Reset in the middle of a replay
        mon_en = 1'b0;
        @(posedge clk); #1;
        out_ready   = 1'b1;
        out_request = 1'b1;
        @(posedge clk); #1;
        out_request = 1'b0;
        repeat (20) @(posedge clk);
        #1;
        chk("midrep_sending", 32'(out_sending), 32'd1);
        rst = 1'b1;
        @(negedge clk);
        chk("midrst_out_valid", 32'(image_out_valid), 32'd0);
        chk("midrst_out_data", 32'(image_out_data), 32'd0);
        chk("midrst_out_start_stop", 32'({image_out_start, image_out_stop}), 32'd0);
        chk("midrst_out_sending", 32'(out_sending), 32'd0);
        chk("midrst_in_request", 32'(image_in_request), 32'd0);
        chk("midrst_in_receiving", 32'(in_receiving), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("postrst_idle", 32'(out_sending), 32'd0);
        probe("postrst_ram_kept", 0, 0, pix_val(2, 0));

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
